// File: rtl/traffic_control.sv
// -----------------------------------------------------------------------------
// traffic_control
//   Fixed-time controller for a two-approach (NS / EW) four-way intersection.
//   Eight-phase Moore FSM: NS green, NS yellow, NS protected left, all-red,
//   EW green, EW yellow, EW protected left, all-red, then wrap. Each phase is
//   held for a parameterised number of clock cycles by an 8-bit phase counter.
//   Lamp outputs decode the registered state only.
//
// Parameters
//   T_GREEN  : cycles in each straight-through green phase (1..255)
//   T_YELLOW : cycles in each yellow phase                 (1..255)
//   T_LEFT   : cycles in each protected free-left phase    (1..255)
//   T_ALLRED : cycles in each all-red clearance phase      (1..255)
//
// Ports
//   clk          in   system clock, all state changes on the rising edge
//   reset        in   synchronous active-low reset (0 = reset)
//   Red_NS       out  NS red lamp
//   Yellow_NS    out  NS yellow lamp
//   Green_NS     out  NS green lamp
//   freeLeft_NS  out  NS protected left-turn arrow
//   Red_EW       out  EW red lamp
//   Yellow_EW    out  EW yellow lamp
//   Green_EW     out  EW green lamp
//   freeLeft_EW  out  EW protected left-turn arrow
// -----------------------------------------------------------------------------
module traffic_control #(
  parameter int unsigned T_GREEN  = 8,
  parameter int unsigned T_YELLOW = 3,
  parameter int unsigned T_LEFT   = 4,
  parameter int unsigned T_ALLRED = 1
) (
  input  logic clk,
  input  logic reset,
  output logic Red_NS,
  output logic Yellow_NS,
  output logic Green_NS,
  output logic freeLeft_NS,
  output logic Red_EW,
  output logic Yellow_EW,
  output logic Green_EW,
  output logic freeLeft_EW
);

  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    NS_L = 3'd2,
    AR1  = 3'd3,
    EW_G = 3'd4,
    EW_Y = 3'd5,
    EW_L = 3'd6,
    AR2  = 3'd7
  } state_t;

  // Terminal count for each phase: the counter value on which the next edge
  // leaves the phase.
  localparam logic [7:0] GREEN_LAST  = 8'(T_GREEN  - 1);
  localparam logic [7:0] YELLOW_LAST = 8'(T_YELLOW - 1);
  localparam logic [7:0] LEFT_LAST   = 8'(T_LEFT   - 1);
  localparam logic [7:0] ALLRED_LAST = 8'(T_ALLRED - 1);

  state_t     state_reg, state_next;
  logic [7:0] count_reg, count_next;
  logic [7:0] phase_last;

  // Duration decode for the current phase.
  always_comb begin
    phase_last = 8'd0;
    case (state_reg)
      NS_G, EW_G: phase_last = GREEN_LAST;
      NS_Y, EW_Y: phase_last = YELLOW_LAST;
      NS_L, EW_L: phase_last = LEFT_LAST;
      AR1,  AR2:  phase_last = ALLRED_LAST;
      default:    phase_last = 8'd0;
    endcase
  end

  // Next-state / counter logic. The >= compare means a counter that somehow
  // overshoots its terminal value still leaves the phase instead of wrapping
  // through 255.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg + 8'd1;
    if (count_reg >= phase_last) begin
      count_next = 8'd0;
      case (state_reg)
        NS_G:    state_next = NS_Y;
        NS_Y:    state_next = NS_L;
        NS_L:    state_next = AR1;
        AR1:     state_next = EW_G;
        EW_G:    state_next = EW_Y;
        EW_Y:    state_next = EW_L;
        EW_L:    state_next = AR2;
        AR2:     state_next = NS_G;
        default: state_next = AR2;
      endcase
    end
    // Any encoding outside the enumerated set falls back to clearance.
    if (!(state_reg inside {NS_G, NS_Y, NS_L, AR1, EW_G, EW_Y, EW_L, AR2})) begin
      state_next = AR2;
      count_next = 8'd0;
    end
  end

  // State register. Reset parks the controller in the all-red clearance that
  // precedes NS green, so release leads straight into a normal NS_G entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= AR2;
      count_reg <= 8'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // Lamp decode from the registered state only.
  always_comb begin
    Red_NS      = 1'b0;
    Yellow_NS   = 1'b0;
    Green_NS    = 1'b0;
    freeLeft_NS = 1'b0;
    Red_EW      = 1'b0;
    Yellow_EW   = 1'b0;
    Green_EW    = 1'b0;
    freeLeft_EW = 1'b0;
    case (state_reg)
      NS_G: begin
        Green_NS = 1'b1;
        Red_EW   = 1'b1;
      end
      NS_Y: begin
        Yellow_NS = 1'b1;
        Red_EW    = 1'b1;
      end
      NS_L: begin
        Red_NS      = 1'b1;
        freeLeft_NS = 1'b1;
        Red_EW      = 1'b1;
      end
      EW_G: begin
        Green_EW = 1'b1;
        Red_NS   = 1'b1;
      end
      EW_Y: begin
        Yellow_EW = 1'b1;
        Red_NS    = 1'b1;
      end
      EW_L: begin
        Red_EW      = 1'b1;
        freeLeft_EW = 1'b1;
        Red_NS      = 1'b1;
      end
      default: begin
        // AR1, AR2 and anything unexpected: all-red.
        Red_NS = 1'b1;
        Red_EW = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_control.sv
// -----------------------------------------------------------------------------
// tb_traffic_control
//   Self-checking bench for traffic_control. Two instances: one with default
//   timing, one with overridden timing (2/1/1/2). Expected lamp vectors are
//   built from the phase table and durations, pushed to a queue as the bench
//   advances the clock, and popped/compared one per cycle.
//   Lamp vector packing:
//   {Red_NS, Yellow_NS, Green_NS, freeLeft_NS, Red_EW, Yellow_EW, Green_EW, freeLeft_EW}
// -----------------------------------------------------------------------------
module tb_traffic_control;

  localparam logic [7:0] L_NSG = 8'h28;
  localparam logic [7:0] L_NSY = 8'h48;
  localparam logic [7:0] L_NSL = 8'h98;
  localparam logic [7:0] L_AR  = 8'h88;
  localparam logic [7:0] L_EWG = 8'h82;
  localparam logic [7:0] L_EWY = 8'h84;
  localparam logic [7:0] L_EWL = 8'h89;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  logic a_red_ns, a_yel_ns, a_grn_ns, a_left_ns, a_red_ew, a_yel_ew, a_grn_ew, a_left_ew;
  logic b_red_ns, b_yel_ns, b_grn_ns, b_left_ns, b_red_ew, b_yel_ew, b_grn_ew, b_left_ew;
  logic [7:0] lamps_a, lamps_b;

  assign lamps_a = {a_red_ns, a_yel_ns, a_grn_ns, a_left_ns, a_red_ew, a_yel_ew, a_grn_ew, a_left_ew};
  assign lamps_b = {b_red_ns, b_yel_ns, b_grn_ns, b_left_ns, b_red_ew, b_yel_ew, b_grn_ew, b_left_ew};

  traffic_control dut_a (
    .clk         (clk),
    .reset       (rst_a),
    .Red_NS      (a_red_ns),
    .Yellow_NS   (a_yel_ns),
    .Green_NS    (a_grn_ns),
    .freeLeft_NS (a_left_ns),
    .Red_EW      (a_red_ew),
    .Yellow_EW   (a_yel_ew),
    .Green_EW    (a_grn_ew),
    .freeLeft_EW (a_left_ew)
  );

  traffic_control #(
    .T_GREEN (2),
    .T_YELLOW(1),
    .T_LEFT  (1),
    .T_ALLRED(2)
  ) dut_b (
    .clk         (clk),
    .reset       (rst_b),
    .Red_NS      (b_red_ns),
    .Yellow_NS   (b_yel_ns),
    .Green_NS    (b_grn_ns),
    .freeLeft_NS (b_left_ns),
    .Red_EW      (b_red_ew),
    .Yellow_EW   (b_yel_ew),
    .Green_EW    (b_grn_ew),
    .freeLeft_EW (b_left_ew)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Safety invariants over one lamp vector.
  function automatic logic inv_ok(input logic [7:0] v);
    logic rn, yn, gn, ln, re, ye, ge, le;
    {rn, yn, gn, ln, re, ye, ge, le} = v;
    inv_ok = ((2'(rn) + 2'(yn) + 2'(gn)) == 2'd1) &&
             ((2'(re) + 2'(ye) + 2'(ge)) == 2'd1) &&
             !(gn && ge) && !(gn && le) && !(ge && ln) && !(ln && le) &&
             (!ln || rn) && (!le || re);
  endfunction

  // Push one full period, starting at NS green entry.
  task automatic push_period(input int tg, input int ty, input int tl, input int ta);
    for (int i = 0; i < tg; i++) exp_q.push_back(L_NSG);
    for (int i = 0; i < ty; i++) exp_q.push_back(L_NSY);
    for (int i = 0; i < tl; i++) exp_q.push_back(L_NSL);
    for (int i = 0; i < ta; i++) exp_q.push_back(L_AR);
    for (int i = 0; i < tg; i++) exp_q.push_back(L_EWG);
    for (int i = 0; i < ty; i++) exp_q.push_back(L_EWY);
    for (int i = 0; i < tl; i++) exp_q.push_back(L_EWL);
    for (int i = 0; i < ta; i++) exp_q.push_back(L_AR);
  endtask

  task automatic test_reset;
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (lamps_a !== L_AR) begin
        n_fail++;
        $display("FAIL reset_a cycle %0d: got %02h expected %02h", i, lamps_a, L_AR);
      end
      n_checks++;
      if (lamps_b !== L_AR) begin
        n_fail++;
        $display("FAIL reset_b cycle %0d: got %02h expected %02h", i, lamps_b, L_AR);
      end
      @(posedge clk);
    end
    #1;
  endtask

  // Release dut_a and follow three full periods; also measure NS_G recurrence.
  task automatic test_sequence;
    logic [7:0] e;
    logic [7:0] prev;
    int last_entry, entries;
    exp_q.delete();
    push_period(8, 3, 4, 1);
    push_period(8, 3, 4, 1);
    push_period(8, 3, 4, 1);
    last_entry = -1;
    entries = 0;
    prev = lamps_a;
    rst_a = 1'b1;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (lamps_a !== e) begin
        n_fail++;
        $display("FAIL seq_a cyc %0d: got %02h expected %02h", cyc, lamps_a, e);
      end
      if (lamps_a[5] && !prev[5]) begin
        entries++;
        if (last_entry >= 0) begin
          n_checks++;
          if (cyc - last_entry != 32) begin
            n_fail++;
            $display("FAIL period_a: got %0d expected 32", cyc - last_entry);
          end
        end
        last_entry = cyc;
      end
      prev = lamps_a;
    end
    n_checks++;
    if (entries != 3) begin
      n_fail++;
      $display("FAIL nsg_entries_a: got %0d expected 3", entries);
    end
  endtask

  // Continue running dut_a for 224 cycles checking lamps and invariants.
  task automatic test_invariants;
    logic [7:0] e;
    exp_q.delete();
    for (int p = 0; p < 7; p++) push_period(8, 3, 4, 1);
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (lamps_a !== e) begin
        n_fail++;
        $display("FAIL run_a cyc %0d: got %02h expected %02h", cyc, lamps_a, e);
      end
      n_checks++;
      if (inv_ok(lamps_a) !== 1'b1) begin
        n_fail++;
        $display("FAIL invariant_a cyc %0d: lamps %02h violate safety rules", cyc, lamps_a);
      end
    end
  endtask

  // Abort dut_a in EW_G at counter 5, then confirm a clean restart.
  task automatic test_mid_reset;
    logic [7:0] e;
    rst_a = 1'b0;
    @(posedge clk);
    #1;
    rst_a = 1'b1;
    exp_q.delete();
    push_period(8, 3, 4, 1);
    // 16 cycles of NS phases + AR1, then EW_G counts 0..5.
    for (int i = 0; i < 22; i++) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (lamps_a !== e) begin
        n_fail++;
        $display("FAIL mid_pre cyc %0d: got %02h expected %02h", cyc, lamps_a, e);
      end
    end
    exp_q.delete();
    rst_a = 1'b0;
    exp_q.push_back(L_AR);
    exp_q.push_back(L_AR);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (lamps_a !== e) begin
        n_fail++;
        $display("FAIL mid_abort cyc %0d: got %02h expected %02h", cyc, lamps_a, e);
      end
    end
    rst_a = 1'b1;
    push_period(8, 3, 4, 1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (lamps_a !== e) begin
        n_fail++;
        $display("FAIL mid_restart cyc %0d: got %02h expected %02h", cyc, lamps_a, e);
      end
    end
    exp_q.delete();
  endtask

  // dut_b (2/1/1/2) was held in reset; release and check three 12-cycle periods.
  task automatic test_override;
    logic [7:0] e;
    logic [7:0] prev;
    int last_entry;
    exp_q.delete();
    // T_ALLRED=2: one more AR cycle after release before NS_G.
    exp_q.push_back(L_AR);
    push_period(2, 1, 1, 2);
    push_period(2, 1, 1, 2);
    push_period(2, 1, 1, 2);
    last_entry = -1;
    prev = lamps_b;
    rst_b = 1'b1;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (lamps_b !== e) begin
        n_fail++;
        $display("FAIL seq_b cyc %0d: got %02h expected %02h", cyc, lamps_b, e);
      end
      n_checks++;
      if (inv_ok(lamps_b) !== 1'b1) begin
        n_fail++;
        $display("FAIL invariant_b cyc %0d: lamps %02h violate safety rules", cyc, lamps_b);
      end
      if (lamps_b[5] && !prev[5]) begin
        if (last_entry >= 0) begin
          n_checks++;
          if (cyc - last_entry != 12) begin
            n_fail++;
            $display("FAIL period_b: got %0d expected 12", cyc - last_entry);
          end
        end
        last_entry = cyc;
      end
      prev = lamps_b;
    end
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    test_reset();
    test_sequence();
    test_invariants();
    test_mid_reset();
    test_override();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
